// File: rtl/alu_result_stage.sv
// Execute->writeback result stage: 2-entry skid buffer, x0 squash, flush and bypass lookup.
// Optional macro ALU_FLAG_STICKY_EN adds sticky flag accumulation (sticky_clr / sticky_flags).
// Flag bit order: [0] overflow, [1] underflow, [2] invalid_op.
module alu_result_stage #(
   parameter int WIDTH = 64,
   parameter int RD_W  = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_result,
   input  logic [2:0]       in_flags,
   input  logic [RD_W-1:0]  in_rd,
   input  logic             in_wb_en,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic [2:0]       out_flags,
   output logic [RD_W-1:0]  out_rd,
   output logic             out_wb_en,
`ifdef ALU_FLAG_STICKY_EN
   input  logic             sticky_clr,
   output logic [2:0]       sticky_flags,
`endif
   input  logic [RD_W-1:0]  lookup_rd,
   output logic             lookup_hit,
   output logic [WIDTH-1:0] lookup_data,
   output logic [1:0]       occupancy
);

   logic [WIDTH-1:0] res_q [2];
   logic [2:0]       flg_q [2];
   logic [RD_W-1:0]  rd_q  [2];
   logic             wb_q  [2];

   logic [1:0] count_q, count_d;
   logic       head_q, head_d;
   logic       tail_q, tail_d;
   logic       push, pop;

   assign in_ready  = (count_q != 2'd2);
   assign out_valid = (count_q != 2'd0);
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;
   assign occupancy = count_q;

   assign out_result = res_q[head_q];
   assign out_flags  = flg_q[head_q];
   assign out_rd     = rd_q[head_q];
   assign out_wb_en  = wb_q[head_q];

   always_comb begin
      count_d = count_q;
      head_d  = head_q;
      tail_d  = tail_q;
      if (flush) begin
         count_d = 2'd0;
         head_d  = 1'b0;
         tail_d  = 1'b0;
      end else begin
         if (push) tail_d = ~tail_q;
         if (pop)  head_d = ~head_q;
         case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= 2'd0;
         head_q  <= 1'b0;
         tail_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
      end
   end

   // Storage is cleared on reset so the head fields read as zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            res_q[i] <= '0;
            flg_q[i] <= '0;
            rd_q[i]  <= '0;
            wb_q[i]  <= 1'b0;
         end
      end else if (push && !flush) begin
         res_q[tail_q] <= in_result;
         flg_q[tail_q] <= in_flags;
         rd_q[tail_q]  <= in_rd;
         wb_q[tail_q]  <= in_wb_en & (in_rd != '0);
      end
   end

   logic young_idx, old_idx;
   logic hit_young, hit_old, lookup_nz;

   // Youngest entry sits just behind the tail; the older one is only live when full.
   always_comb begin
      young_idx   = ~tail_q;
      old_idx     = tail_q;
      lookup_nz   = (lookup_rd != '0);
      hit_young   = (count_q != 2'd0) && wb_q[young_idx] && (rd_q[young_idx] == lookup_rd);
      hit_old     = (count_q == 2'd2) && wb_q[old_idx] && (rd_q[old_idx] == lookup_rd);
      lookup_hit  = lookup_nz && (hit_young || hit_old);
      lookup_data = '0;
      if (lookup_nz && hit_young)     lookup_data = res_q[young_idx];
      else if (lookup_nz && hit_old)  lookup_data = res_q[old_idx];
   end

`ifdef ALU_FLAG_STICKY_EN
   logic [2:0] sticky_q, sticky_d;

   always_comb begin
      sticky_d = (sticky_clr ? 3'b000 : sticky_q) | (pop ? out_flags : 3'b000);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sticky_q <= 3'b000;
      else        sticky_q <= sticky_d;
   end

   assign sticky_flags = sticky_q;
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench for alu_result_stage against a queue-based reference model.
module tb_alu_result_stage;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] in_result;
   logic [2:0]  in_flags;
   logic [4:0]  in_rd;
   logic        in_wb_en;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_result;
   logic [2:0]  out_flags;
   logic [4:0]  out_rd;
   logic        out_wb_en;
   logic [4:0]  lookup_rd;
   logic        lookup_hit;
   logic [63:0] lookup_data;
   logic [1:0]  occupancy;
`ifdef ALU_FLAG_STICKY_EN
   logic        sticky_clr;
   logic [2:0]  sticky_flags;
`endif

   integer tests_run    = 0;
   integer tests_failed = 0;

   typedef struct packed {
      logic [63:0] res;
      logic [2:0]  flg;
      logic [4:0]  rd;
      logic        wb;
   } ent_t;

   ent_t       q[$];
   logic [2:0] stk;

   alu_result_stage #(.WIDTH(64), .RD_W(5)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_result(in_result), .in_flags(in_flags), .in_rd(in_rd), .in_wb_en(in_wb_en),
      .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_result(out_result), .out_flags(out_flags), .out_rd(out_rd), .out_wb_en(out_wb_en),
`ifdef ALU_FLAG_STICKY_EN
      .sticky_clr(sticky_clr), .sticky_flags(sticky_flags),
`endif
      .lookup_rd(lookup_rd), .lookup_hit(lookup_hit), .lookup_data(lookup_data),
      .occupancy(occupancy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void model_lookup(input logic [4:0] lr, output logic h, output logic [63:0] d);
      h = 1'b0;
      d = 64'd0;
      if (lr != 5'd0) begin
         for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].wb && q[i].rd == lr) begin
               h = 1'b1;
               d = q[i].res;
               break;
            end
         end
      end
   endfunction

   // Advance one clock and apply the same transfer to the reference model.
   task automatic tick();
      logic   do_push, do_pop, clr;
      ent_t   e;
      do_push = in_valid && (q.size() != 2);
      do_pop  = out_ready && (q.size() != 0);
      e.res = in_result;
      e.flg = in_flags;
      e.rd  = in_rd;
      e.wb  = in_wb_en && (in_rd != 5'd0);
`ifdef ALU_FLAG_STICKY_EN
      clr = sticky_clr;
`else
      clr = 1'b0;
`endif
      @(posedge clk);
      #1;
      if (clr) stk = 3'b000;
      if (do_pop) stk = stk | q[0].flg;
      if (flush) q.delete();
      else begin
         if (do_pop)  void'(q.pop_front());
         if (do_push) q.push_back(e);
      end
      if (!rst_n) begin
         q.delete();
         stk = 3'b000;
      end
   endtask

   task automatic drain();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (3) tick();
      out_ready = 1'b0;
   endtask

   task automatic push_one(input logic [63:0] r, input logic [4:0] rd, input logic [2:0] f);
      in_valid  = 1'b1;
      in_result = r;
      in_rd     = rd;
      in_wb_en  = 1'b1;
      in_flags  = f;
      tick();
      in_valid  = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      in_valid = 1'b1; in_result = 64'h5; in_rd = 5'd3; in_wb_en = 1'b1; in_flags = 3'b000;
      repeat (3) tick();
      #1;
      tests_run++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || occupancy !== 2'd0 || out_result !== 64'd0 || lookup_hit !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_state: out_valid=%b in_ready=%b occ=%0d out_result=%h hit=%b, required 0 1 0 0 0",
                  out_valid, in_ready, occupancy, out_result, lookup_hit);
      end
      rst_n = 1'b1;
      tick();
      in_valid = 1'b0;
      #1;
      tests_run++;
      if (out_valid !== 1'b1 || out_result !== 64'h5 || out_rd !== 5'd3) begin
         tests_failed++;
         $display("FAIL first_push_latency: out_valid=%b out_result=%h out_rd=%0d, required 1 5 3",
                  out_valid, out_result, out_rd);
      end
      drain();
   endtask

   task automatic test_fill_drain();
      out_ready = 1'b0;
      push_one(64'h11, 5'd1, 3'b000);
      push_one(64'h22, 5'd2, 3'b000);
      in_valid = 1'b1; in_result = 64'h99; in_rd = 5'd9;
      #1;
      tests_run++;
      if (occupancy !== 2'd2 || in_ready !== 1'b0) begin
         tests_failed++;
         $display("FAIL full_backpressure: occ=%0d in_ready=%b, required 2 0", occupancy, in_ready);
      end
      tick();
      in_valid = 1'b0;
      #1;
      tests_run++;
      if (occupancy !== 2'd2 || out_result !== 64'h11) begin
         tests_failed++;
         $display("FAIL full_ignore_push: occ=%0d head=%h, required 2 11", occupancy, out_result);
      end
      out_ready = 1'b1;
      tick();
      #1;
      tests_run++;
      if (out_result !== 64'h22 || occupancy !== 2'd1) begin
         tests_failed++;
         $display("FAIL drain_order: head=%h occ=%0d, required 22 1", out_result, occupancy);
      end
      tick();
      #1;
      tests_run++;
      if (occupancy !== 2'd0 || out_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL drain_empty: occ=%0d out_valid=%b, required 0 0", occupancy, out_valid);
      end
      out_ready = 1'b0;
   endtask

   task automatic test_push_pop_wrap();
      out_ready = 1'b0;
      push_one(64'h30, 5'd4, 3'b000);
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1; in_result = 64'h33 + 64'(i); in_rd = 5'd4; in_wb_en = 1'b1;
         out_ready = 1'b1;
         tick();
         #1;
         tests_run++;
         if (occupancy !== 2'd1 || out_result !== (64'h33 + 64'(i))) begin
            tests_failed++;
            $display("FAIL push_pop_wrap[%0d]: occ=%0d head=%h, required 1 %h",
                     i, occupancy, out_result, 64'h33 + 64'(i));
         end
      end
      drain();
   endtask

   task automatic test_x0_squash();
      logic h;
      logic [63:0] d;
      out_ready = 1'b0;
      push_one(64'h77, 5'd0, 3'b000);
      lookup_rd = 5'd0;
      #1;
      model_lookup(lookup_rd, h, d);
      tests_run++;
      if (out_wb_en !== 1'b0 || lookup_hit !== 1'b0 || h !== 1'b0 || out_result !== 64'h77) begin
         tests_failed++;
         $display("FAIL x0_squash: wb_en=%b hit=%b result=%h, required 0 0 77", out_wb_en, lookup_hit, out_result);
      end
      drain();
   endtask

   task automatic test_bypass();
      out_ready = 1'b0;
      push_one(64'hAA, 5'd7, 3'b000);
      push_one(64'hBB, 5'd7, 3'b000);
      lookup_rd = 5'd7;
      #1;
      tests_run++;
      if (lookup_hit !== 1'b1 || lookup_data !== 64'hBB) begin
         tests_failed++;
         $display("FAIL bypass_youngest: hit=%b data=%h, required 1 bb", lookup_hit, lookup_data);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      #1;
      tests_run++;
      if (lookup_hit !== 1'b1 || lookup_data !== 64'hBB) begin
         tests_failed++;
         $display("FAIL bypass_after_pop: hit=%b data=%h, required 1 bb", lookup_hit, lookup_data);
      end
      lookup_rd = 5'd8;
      #1;
      tests_run++;
      if (lookup_hit !== 1'b0 || lookup_data !== 64'd0) begin
         tests_failed++;
         $display("FAIL bypass_miss: hit=%b data=%h, required 0 0", lookup_hit, lookup_data);
      end
      drain();
   endtask

   task automatic test_flush();
      out_ready = 1'b0;
      push_one(64'h1, 5'd1, 3'b000);
      push_one(64'h2, 5'd2, 3'b000);
      flush = 1'b1; in_valid = 1'b1; in_result = 64'h3; in_rd = 5'd3;
      #1;
      tests_run++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
         tests_failed++;
         $display("FAIL flush_same_cycle: in_ready=%b out_valid=%b, required 0 1", in_ready, out_valid);
      end
      tick();
      flush = 1'b0; in_valid = 1'b0;
      #1;
      tests_run++;
      if (occupancy !== 2'd0 || out_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL flush_full: occ=%0d out_valid=%b, required 0 0", occupancy, out_valid);
      end
      push_one(64'h4, 5'd4, 3'b000);
      flush = 1'b1; in_valid = 1'b1; in_result = 64'h5; out_ready = 1'b1;
      tick();
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      #1;
      tests_run++;
      if (occupancy !== 2'd0 || out_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL flush_push_pop: occ=%0d out_valid=%b, required 0 0", occupancy, out_valid);
      end
   endtask

`ifdef ALU_FLAG_STICKY_EN
   task automatic test_sticky();
      out_ready = 1'b0;
      sticky_clr = 1'b1;
      tick();
      sticky_clr = 1'b0;
      push_one(64'h10, 5'd1, 3'b001);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      #1;
      tests_run++;
      if (sticky_flags !== 3'b001) begin
         tests_failed++;
         $display("FAIL sticky_set: sticky=%b, required 001", sticky_flags);
      end
      push_one(64'h20, 5'd2, 3'b010);
      out_ready = 1'b1; sticky_clr = 1'b1;
      tick();
      out_ready = 1'b0; sticky_clr = 1'b0;
      #1;
      tests_run++;
      if (sticky_flags !== 3'b010) begin
         tests_failed++;
         $display("FAIL sticky_clr_set: sticky=%b, required 010", sticky_flags);
      end
      push_one(64'h30, 5'd3, 3'b000);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      #1;
      tests_run++;
      if (sticky_flags !== 3'b010) begin
         tests_failed++;
         $display("FAIL sticky_flush: sticky=%b, required 010", sticky_flags);
      end
   endtask
`endif

   task automatic test_random();
      logic        h;
      logic [63:0] d;
      logic        bad;
      for (int c = 0; c < 400; c++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         flush     = ($urandom_range(0, 19) == 0);
         in_result = {$urandom, $urandom};
         in_flags  = 3'($urandom_range(0, 7));
         in_rd     = 5'($urandom_range(0, 7));
         in_wb_en  = ($urandom_range(0, 3) != 0);
         lookup_rd = 5'($urandom_range(0, 7));
`ifdef ALU_FLAG_STICKY_EN
         sticky_clr = ($urandom_range(0, 9) == 0);
`endif
         #1;
         model_lookup(lookup_rd, h, d);
         bad = 1'b0;
         if (in_ready !== (q.size() != 2) || out_valid !== (q.size() != 0) || occupancy !== 2'(q.size())) bad = 1'b1;
         if (q.size() != 0) begin
            if (out_result !== q[0].res || out_flags !== q[0].flg || out_rd !== q[0].rd || out_wb_en !== q[0].wb) bad = 1'b1;
         end
         if (lookup_hit !== h || lookup_data !== d) bad = 1'b1;
`ifdef ALU_FLAG_STICKY_EN
         if (sticky_flags !== stk) bad = 1'b1;
`endif
         tests_run++;
         if (bad) begin
            tests_failed++;
            $display("FAIL random[%0d]: occ=%0d rdy=%b vld=%b res=%h rd=%0d wb=%b hit=%b data=%h, required occ=%0d hit=%b data=%h",
                     c, occupancy, in_ready, out_valid, out_result, out_rd, out_wb_en, lookup_hit, lookup_data,
                     q.size(), h, d);
         end
         tick();
      end
      flush = 1'b0;
`ifdef ALU_FLAG_STICKY_EN
      sticky_clr = 1'b0;
`endif
      drain();
   endtask

   task automatic test_async_reset();
      out_ready = 1'b0;
      push_one(64'hDEAD, 5'd5, 3'b111);
      push_one(64'hBEEF, 5'd6, 3'b011);
      lookup_rd = 5'd6;
      #3;
      rst_n = 1'b0;
      #1;
      tests_run++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || occupancy !== 2'd0 || out_result !== 64'd0 ||
          out_flags !== 3'd0 || out_rd !== 5'd0 || out_wb_en !== 1'b0 || lookup_hit !== 1'b0 || lookup_data !== 64'd0) begin
         tests_failed++;
         $display("FAIL async_reset: vld=%b rdy=%b occ=%0d res=%h flg=%b rd=%0d wb=%b hit=%b data=%h, required all zero with rdy=1",
                  out_valid, in_ready, occupancy, out_result, out_flags, out_rd, out_wb_en, lookup_hit, lookup_data);
      end
`ifdef ALU_FLAG_STICKY_EN
      tests_run++;
      if (sticky_flags !== 3'd0) begin
         tests_failed++;
         $display("FAIL async_reset_sticky: sticky=%b, required 000", sticky_flags);
      end
`endif
      q.delete();
      stk = 3'b000;
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   initial begin
      stk       = 3'b000;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_result = 64'd0;
      in_flags  = 3'd0;
      in_rd     = 5'd0;
      in_wb_en  = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b0;
      lookup_rd = 5'd0;
`ifdef ALU_FLAG_STICKY_EN
      sticky_clr = 1'b0;
`endif
      test_reset();
      test_fill_drain();
      test_push_pop_wrap();
      test_x0_squash();
      test_bypass();
      test_flush();
`ifdef ALU_FLAG_STICKY_EN
      test_sticky();
`endif
      test_random();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
